calc_adder_sequencer: RTL and testbench

Control stage directly upstream of the 16-bit carry-select adder in the calculator datapath, and also the consumer of its sum/carry.
- Accepts an opcode and two operands over a valid/ready handshake.
- Drives the adder's a/b/c_in, captures sum/carry, and returns a registered result with flags.
- ADD and SUB take one adder pass. MUL is unsigned shift-add using 16 sequential adder passes.

---
 rtl/calc_adder_sequencer.sv | 146 ++++++++++++++
 tb/tb_calc_adder_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/calc_adder_sequencer.sv
// Sequencer for the calculator's 16-bit carry-select adder: ADD/SUB in one pass,
// unsigned MUL as 16 shift-add passes, registered result held until downstream accepts.
module calc_adder_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry_out,
    output logic               overflow,
    output logic               err
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     mreg_q, mreg_d;     // operand B for ADD/SUB, shifting multiplier for MUL
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 err_q, err_d;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign err       = err_q;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == S_EXEC) begin
            add_a   = a_q;
            add_b   = (op_q == OP_SUB) ? ~mreg_q : mreg_q;
            add_cin = (op_q == OP_SUB);
        end else if (state_q == S_MUL) begin
            add_a = acc_q;
            add_b = mreg_q[0] ? a_q : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        mreg_d   = mreg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    a_d    = opa;
                    mreg_d = opb;
                    acc_d  = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (op == OP_ADD || op == OP_SUB) begin
                        state_d = S_EXEC;
                    end else if (op == OP_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        result_d = '0;
                        carry_d  = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                result_d = {{WIDTH{1'b0}}, add_sum};
                carry_d  = add_cout;
                ovf_d    = (a_q[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
                state_d  = S_DONE;
            end
            S_MUL: begin
                acc_d  = {add_cout, add_sum[WIDTH-1:1]};
                mreg_d = {add_sum[0], mreg_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d    = '0;
                    result_d = {acc_d, mreg_d};
                    carry_d  = 1'b0;
                    ovf_d    = (acc_d != '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            mreg_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            mreg_q   <= mreg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_calc_adder_sequencer.sv
// Directed bench for calc_adder_sequencer with a behavioural adder closing the loop.
module tb_calc_adder_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] opa = '0, opb = '0;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out, overflow, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

    calc_adder_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .opa(opa), .opb(opb), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry_out(carry_out),
        .overflow(overflow), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input logic exp_c, input logic exp_v, input logic exp_e);
        int lat;
        logic busy_ok;
        op = o; opa = a; opb = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        if (o == 2'b00 || o == 2'b01) begin
            check({tag, "_add_a"},   {16'h0, add_a}, {16'h0, a});
            check({tag, "_add_b"},   {16'h0, add_b}, {16'h0, (o == 2'b01) ? ~b : b});
            check({tag, "_add_cin"}, {31'h0, add_cin}, {31'h0, o[0]});
        end
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            step();
            lat++;
        end
        check({tag, "_latency"},  lat, exp_lat);
        check({tag, "_busy"},     {31'h0, busy_ok && !in_ready}, 32'h1);
        check({tag, "_result"},   result, exp_res);
        check({tag, "_carry"},    {31'h0, carry_out}, {31'h0, exp_c});
        check({tag, "_overflow"}, {31'h0, overflow}, {31'h0, exp_v});
        check({tag, "_err"},      {31'h0, err}, {31'h0, exp_e});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "_rel_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        logic saw_valid;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", {31'h0, in_ready}, 32'h1);
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {29'h0, carry_out, overflow, err}, 32'h0);
        check("reset_adder", {add_cin, add_a, add_b[14:0]}, 32'h0);

        run_op("add1", 2'b00, 16'h1234, 16'h0FED, 2, 32'h0000_2221, 1'b0, 1'b0, 1'b0);
        release_result("add1");
        check("idle_adder_a", {16'h0, add_a}, 32'h0);
        run_op("add2", 2'b00, 16'hFFFF, 16'h0001, 2, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        release_result("add2");
        run_op("add3", 2'b00, 16'h7FFF, 16'h0001, 2, 32'h0000_8000, 1'b0, 1'b1, 1'b0);
        release_result("add3");
        run_op("sub1", 2'b01, 16'h0005, 16'h0007, 2, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0);
        release_result("sub1");
        run_op("sub2", 2'b01, 16'h8000, 16'h0001, 2, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0);
        release_result("sub2");

        run_op("mul1", 2'b10, 16'h00FF, 16'h0101, 17, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        release_result("mul1");
        run_op("mul2", 2'b10, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 1'b0, 1'b1, 1'b0);
        release_result("mul2");
        run_op("mul3", 2'b10, 16'h1234, 16'h0000, 17, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        release_result("mul3");

        // Backpressure: hold out_ready low while a fresh request waits upstream.
        run_op("bp", 2'b00, 16'h0102, 16'h0304, 2, 32'h0000_0406, 1'b0, 1'b0, 1'b0);
        op = 2'b00; opa = 16'hAAAA; opb = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            check("bp_hold_ready", {31'h0, in_ready}, 32'h0);
            check("bp_hold_result", result, 32'h0000_0406);
            check("bp_hold_flags", {29'h0, carry_out, overflow, err}, 32'h0);
        end
        in_valid = 1'b0;
        release_result("bp");

        run_op("rsvd", 2'b11, 16'h5555, 16'h6666, 1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        release_result("rsvd");
        run_op("err_clr", 2'b00, 16'h0001, 16'h0002, 2, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        release_result("err_clr");

        // Reset in the middle of a multiply.
        op = 2'b10; opa = 16'hFFFF; opb = 16'hFFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mid_mul_busy", {31'h0, in_ready}, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'h0, carry_out, overflow, err}, 32'h0);
        check("rst_adder", {add_cin, add_a, add_b[14:0]}, 32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_no_valid", {31'h0, saw_valid}, 32'h0);
        check("rst_still_idle", {31'h0, in_ready}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
